// File: rtl/fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_queue
// Description : Circular instruction queue between fetch and decode. Captures
//               {Instr, PC, PC+4} triples from fetch, presents the oldest entry
//               to decode with a valid/ready handshake, throttles the PC via
//               PC_En when full, and empties itself on a control-flow flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [31:0]              Instr_F,
    input  logic [31:0]              PC_F,
    input  logic [31:0]              PC_Plus_4_F,
    input  logic                     Valid_F,
    input  logic                     Flush,
    input  logic                     Ready_D,
    output logic                     PC_En,
    output logic                     Valid_D,
    output logic [31:0]              Instr_D,
    output logic [31:0]              PC_D,
    output logic [31:0]              PC_Plus_4_D,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
    localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
    localparam logic [31:0]   C_NOP     = 32'h0000_0013;

    // Reject unusable depths at elaboration time rather than building a
    // queue whose pointers cannot wrap cleanly.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fetch_decode_queue: DEPTH must be a power of 2 and >= 2");
    end

    // Entry layout: [95:64] Instr, [63:32] PC, [31:0] PC+4.
    logic [95:0]   mem_q [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [95:0]   w_head;

    assign w_full  = (count_q == C_DEPTH);
    assign w_empty = (count_q == '0);

    // Both handshakes are gated by status, so overflow/underflow cannot occur.
    assign w_push  = Valid_F & ~w_full;
    assign w_pop   = ~w_empty & Ready_D;

    // Next-state for pointers and occupancy; flush discards everything,
    // including the instruction fetch is presenting this cycle.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + C_CNT_ONE;
                2'b01:   count_d = count_q - C_CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset wins over flush and handshakes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is left unreset; the empty mux hides stale contents.
    always_ff @(posedge CLK) begin
        if (w_push && !Flush && !RST) begin
            mem_q[wr_ptr_q] <= {Instr_F, PC_F, PC_Plus_4_F};
        end
    end

    assign w_head = mem_q[rd_ptr_q];

    // Head presentation: no bypass from fetch, so output depends only on state.
    assign Valid_D     = ~w_empty;
    assign PC_En       = ~w_full;
    assign Count       = count_q;
    assign Instr_D     = w_empty ? C_NOP : w_head[95:64];
    assign PC_D        = w_empty ? 32'h0 : w_head[63:32];
    assign PC_Plus_4_D = w_empty ? 32'h0 : w_head[31:0];

endmodule
`default_nettype wire
